sme_feeder: RTL

Upstream loader for the string-matching engine (SME). Accepts string and pattern records from a bursty byte source over a valid/ready handshake and buffers each complete record. It then replays the record to SME as one gap-free burst on `chardata`/`isstring`/`ispattern`. After each pattern it holds off further traffic until SME reports `valid`.

---
 rtl/sme_feeder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sme_feeder.sv
// sme_feeder: buffers string/pattern records from a bursty byte source and replays each one
// to the SME as a gap-free burst. Optional post-pattern watchdog: define SME_FEEDER_TIMEOUT_EN.
module sme_feeder #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TO_CYC  = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_type,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       sme_valid,
    output logic       busy,
    output logic       ovf,
    output logic       timeout
);

    localparam int AW = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] buffer [STR_MAX];
    logic [5:0] len;
    logic [5:0] idx;
    logic [5:0] max_len;
    logic       rec_type;
    logic       trunc;
    logic       xfer;
    logic       room;
    logic       burst_done;
    logic       wait_expired;

    assign xfer       = in_valid & in_ready;
    assign max_len    = rec_type ? 6'(PAT_MAX) : 6'(STR_MAX);
    assign room       = (len < max_len);
    assign burst_done = (idx == len);

`ifdef SME_FEEDER_TIMEOUT_EN
    logic [7:0] wait_cnt;

    assign wait_expired = (wait_cnt == 8'(TO_CYC - 1));

    // Counter is held at zero outside WAIT, so it starts from zero on every entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 8'd0;
            timeout  <= 1'b0;
        end else begin
            timeout <= (state == WAIT) && !sme_valid && wait_expired;
            if (state != WAIT)
                wait_cnt <= 8'd0;
            else
                wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    assign wait_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (xfer) state_next = in_last ? SEND : LOAD;
            LOAD: if (xfer && in_last) state_next = SEND;
            SEND: if (burst_done) state_next = rec_type ? WAIT : IDLE;
            WAIT: if (sme_valid || wait_expired) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // in_ready is gated by reset so the source sees 0 while reset is held.
    always_comb begin
        in_ready = !reset && ((state == IDLE) || (state == LOAD));
        busy     = (state != IDLE);
    end

    // Record bookkeeping and the registered SME-side burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len       <= 6'd0;
            idx       <= 6'd0;
            rec_type  <= 1'b0;
            trunc     <= 1'b0;
            chardata  <= 8'h00;
            isstring  <= 1'b0;
            ispattern <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            ovf <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        rec_type <= in_type;
                        len      <= 6'd1;
                        idx      <= 6'd0;
                        trunc    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        if (room)
                            len <= len + 6'd1;
                        else
                            trunc <= 1'b1;
                        if (in_last)
                            ovf <= trunc || !room;
                    end
                end
                SEND: begin
                    if (!burst_done) begin
                        chardata  <= buffer[idx[AW-1:0]];
                        isstring  <= !rec_type;
                        ispattern <= rec_type;
                        idx       <= idx + 6'd1;
                    end else begin
                        isstring  <= 1'b0;
                        ispattern <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Record storage; bytes past the per-type maximum are never written.
    always_ff @(posedge clk) begin
        if (xfer) begin
            if (state == IDLE)
                buffer[0] <= in_data;
            else if ((state == LOAD) && room)
                buffer[len[AW-1:0]] <= in_data;
        end
    end

endmodule
